cam_pattern_tx: RTL and testbench

CAM_PATTERN_TX -- requirements
Module: cam_pattern_tx

---
 rtl/cam_pkg.sv | 63 ++++++
 rtl/cam_pattern_gen.sv | 32 +++
 rtl/cam_pattern_tx.sv | 151 +++++++++++++++
 tb/tb_cam_pattern_tx.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// cam_pkg: shared types and constants for the camera pattern transmitter.
// Holds the frame FSM states, pattern codes and RGB565 bar colours.
package cam_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } cam_state_e;

    typedef enum logic [1:0] {
        PAT_SOLID = 2'd0,
        PAT_BARS  = 2'd1,
        PAT_RAMP  = 2'd2,
        PAT_CHECK = 2'd3
    } pattern_e;

    localparam logic [7:0] SOLID_BYTE = 8'hA5;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        c = BAR_BLACK;
        unique case (idx)
            3'd0: c = BAR_WHITE;
            3'd1: c = BAR_YELLOW;
            3'd2: c = BAR_CYAN;
            3'd3: c = BAR_GREEN;
            3'd4: c = BAR_MAGENTA;
            3'd5: c = BAR_RED;
            3'd6: c = BAR_BLUE;
            3'd7: c = BAR_BLACK;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

    // Bits needed to count 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    function automatic int max4(input int a, input int b,
                                input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/cam_pattern_gen.sv
// cam_pattern_gen: maps pattern, pixel position and frame parity
// to one RGB565 colour; purely combinational.
module cam_pattern_gen
    import cam_pkg::*;
(
    input  logic [1:0]  pattern_i,
    input  logic [8:0]  x_i,
    input  logic [5:0]  y_i,
    input  logic [7:0]  frame_cnt_i,
    output logic [15:0] rgb_o
);

    logic unused_bits;
    assign unused_bits = ^{x_i[1:0], y_i[4:0], frame_cnt_i[7:1]};

    always_comb begin
        rgb_o = 16'h0000;
        unique case (pattern_e'(pattern_i))
            PAT_SOLID: rgb_o = {SOLID_BYTE, SOLID_BYTE};
            PAT_BARS:  rgb_o = bar_color(x_i[8:6]);
            PAT_RAMP:  rgb_o = {x_i[7:3], x_i[7:2], x_i[7:3]};
            PAT_CHECK: begin
                if (x_i[5] ^ y_i[5] ^ frame_cnt_i[0])
                    rgb_o = 16'hFFFF;
                else
                    rgb_o = 16'h0000;
            end
            default:   rgb_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/cam_pattern_tx.sv
// cam_pattern_tx: camera-style byte stream source with VSYNC/HREF
// framing and RGB565 test patterns, one byte per two CLKs.
module cam_pattern_tx
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int H_BLANK  = 144,
    parameter int VS_LINES = 3,
    parameter int V_BP     = 17,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       EN,
    input  logic [1:0] PATTERN,
    output logic       PCLK,
    output logic       CamVsync,
    output logic       CamHsync,
    output logic [7:0] CamData,
    output logic       FRAME_DONE
);

    localparam int LINE_BYTES = 2 * H_ACTIVE + H_BLANK;
    localparam int COL_W = clog2_min1(LINE_BYTES);
    localparam int LN_W  =
        clog2_min1(max4(VS_LINES, V_BP, V_ACTIVE, V_FP));

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_BYTES - 1);
    localparam logic [LN_W-1:0]  FP_LAST  = LN_W'(V_FP - 1);

    cam_state_e       state_q, state_d;
    pattern_e         pat_q, pat_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [LN_W-1:0]  line_q, line_d;
    logic [LN_W-1:0]  span_m1;
    logic [7:0]       fcnt_q, fcnt_d;
    logic             pclk_q;
    logic             vs_q, vs_d;
    logic             hs_q, hs_d;
    logic             done_q, done_d;
    logic [7:0]       data_q, data_d;
    logic [15:0]      rgb;
    logic             last_col, last_line;

    always_comb begin
        span_m1 = '0;
        unique case (state_q)
            ST_VSYNC:  span_m1 = LN_W'(VS_LINES - 1);
            ST_VBP:    span_m1 = LN_W'(V_BP - 1);
            ST_ACTIVE: span_m1 = LN_W'(V_ACTIVE - 1);
            ST_VFP:    span_m1 = LN_W'(V_FP - 1);
            default:   span_m1 = '0;
        endcase
    end

    assign last_col  = (col_q == COL_LAST);
    assign last_line = (line_q == span_m1);

    // Everything advances only on the byte edge, where PCLK falls.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        pat_d   = pat_q;
        fcnt_d  = fcnt_q;
        if (pclk_q) begin
            if (state_q == ST_IDLE) begin
                if (EN) begin
                    state_d = ST_VSYNC;
                    col_d   = '0;
                    line_d  = '0;
                    pat_d   = pattern_e'(PATTERN);
                end
            end else if (!last_col) begin
                col_d = col_q + 1'b1;
            end else begin
                col_d = '0;
                if (!last_line) begin
                    line_d = line_q + 1'b1;
                end else begin
                    line_d = '0;
                    unique case (state_q)
                        ST_VSYNC:  state_d = ST_VBP;
                        ST_VBP:    state_d = ST_ACTIVE;
                        ST_ACTIVE: state_d = ST_VFP;
                        ST_VFP: begin
                            state_d = EN ? ST_VSYNC : ST_IDLE;
                            fcnt_d  = fcnt_q + 8'd1;
                        end
                        default:   state_d = ST_IDLE;
                    endcase
                end
            end
        end
    end

    cam_pattern_gen u_gen (
        .pattern_i   (pat_d),
        .x_i         (9'(col_d >> 1)),
        .y_i         (6'(line_d)),
        .frame_cnt_i (fcnt_q),
        .rgb_o       (rgb)
    );

    always_comb begin
        vs_d   = (state_d == ST_VSYNC);
        hs_d   = (state_d == ST_ACTIVE) &&
                 (int'(col_d) < 2 * H_ACTIVE);
        data_d = 8'h00;
        if (hs_d)
            data_d = col_d[0] ? rgb[7:0] : rgb[15:8];
        done_d = pclk_q && (state_d == ST_VFP) &&
                 (col_d == COL_LAST) && (line_d == FP_LAST);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pat_q   <= PAT_SOLID;
            col_q   <= '0;
            line_q  <= '0;
            fcnt_q  <= '0;
            pclk_q  <= 1'b0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            data_q  <= 8'h00;
            done_q  <= 1'b0;
        end else begin
            pclk_q  <= ~pclk_q;
            state_q <= state_d;
            pat_q   <= pat_d;
            col_q   <= col_d;
            line_q  <= line_d;
            fcnt_q  <= fcnt_d;
            done_q  <= done_d;
            if (pclk_q) begin
                vs_q   <= vs_d;
                hs_q   <= hs_d;
                data_q <= data_d;
            end
        end
    end

    assign PCLK       = pclk_q;
    assign CamVsync   = vs_q;
    assign CamHsync   = hs_q;
    assign CamData    = data_q;
    assign FRAME_DONE = done_q;

endmodule

// File: tb/tb_cam_pattern_tx.sv
// tb_cam_pattern_tx: randomized frame-level checks of cam_pattern_tx
// against a line/byte reference built from the pattern rules.
module tb_cam_pattern_tx;

    localparam int HA  = 4;
    localparam int WHA = 512;
    localparam int HB  = 4;
    localparam int VS  = 1;
    localparam int BP  = 1;
    localparam int VA  = 2;
    localparam int VF  = 1;
    localparam int LB  = 2 * HA + HB;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       EN = 1'b0;
    logic [1:0] PATTERN = 2'd0;
    logic       PCLK, CamVsync, CamHsync, FRAME_DONE;
    logic [7:0] CamData;

    logic       EN_w = 1'b0;
    logic [1:0] PATTERN_w = 2'd0;
    logic       PCLK_w, CamVsync_w, CamHsync_w, FRAME_DONE_w;
    logic [7:0] CamData_w;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int done_cnt_w = 0;
    int fc_s = 0;
    int fc_w = 0;

    cam_pattern_tx #(
        .H_ACTIVE(HA), .H_BLANK(HB), .VS_LINES(VS),
        .V_BP(BP), .V_ACTIVE(VA), .V_FP(VF)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .EN(EN), .PATTERN(PATTERN),
        .PCLK(PCLK), .CamVsync(CamVsync), .CamHsync(CamHsync),
        .CamData(CamData), .FRAME_DONE(FRAME_DONE)
    );

    cam_pattern_tx #(
        .H_ACTIVE(WHA), .H_BLANK(HB), .VS_LINES(VS),
        .V_BP(BP), .V_ACTIVE(VA), .V_FP(VF)
    ) dut_w (
        .CLK(CLK), .RST_N(RST_N), .EN(EN_w), .PATTERN(PATTERN_w),
        .PCLK(PCLK_w), .CamVsync(CamVsync_w), .CamHsync(CamHsync_w),
        .CamData(CamData_w), .FRAME_DONE(FRAME_DONE_w)
    );

    always #10 CLK = ~CLK;

    always @(negedge CLK) begin
        if (FRAME_DONE)   done_cnt   <= done_cnt + 1;
        if (FRAME_DONE_w) done_cnt_w <= done_cnt_w + 1;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [10:0] obs(input bit sel);
        if (sel)
            return {FRAME_DONE_w, CamVsync_w, CamHsync_w, CamData_w};
        return {FRAME_DONE, CamVsync, CamHsync, CamData};
    endfunction

    function automatic logic [15:0] pixel(input int pat, input int x,
                                          input int y, input int fc);
        logic [15:0] bars [8];
        int r, g;
        bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        case (pat)
            0: return 16'hA5A5;
            1: return bars[(x / 64) % 8];
            2: begin
                r = (x % 256) / 8;
                g = (x % 256) / 4;
                return 16'((r << 11) | (g << 5) | r);
            end
            default:
                return ((((x / 32) + (y / 32) + fc) % 2) == 1) ?
                       16'hFFFF : 16'h0000;
        endcase
    endfunction

    task automatic next_byte(input bit sel);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 4 && !ok; i++) begin
            @(posedge CLK);
            #1;
            if ((sel ? PCLK_w : PCLK) == 1'b0) ok = 1'b1;
        end
        if (!ok) check("byte_edge_timeout", {31'b0, ok}, 1);
    endtask

    task automatic run_frame(input bit sel, input int pat, input int fc,
                             input bit wait_start, input int drop_k,
                             input int abort_k);
        logic [10:0] exp_q[$];
        int ha, lb, tot, x, y;
        bit vs, act, hs, dn, found;
        logic [15:0] px;
        logic [7:0] d;
        ha  = sel ? WHA : HA;
        lb  = 2 * ha + HB;
        tot = VS + BP + VA + VF;
        for (int l = 0; l < tot; l++) begin
            for (int b = 0; b < lb; b++) begin
                vs  = (l < VS);
                act = (l >= VS + BP) && (l < VS + BP + VA);
                hs  = act && (b < 2 * ha);
                x   = b / 2;
                y   = l - VS - BP;
                px  = pixel(pat, x, y, fc);
                d   = hs ? ((b % 2 == 0) ? px[15:8] : px[7:0]) : 8'h00;
                dn  = (l == tot - 1) && (b == lb - 1);
                exp_q.push_back({dn, vs, hs, d});
            end
        end
        if (wait_start) begin
            found = 1'b0;
            for (int i = 0; i < 8 && !found; i++) begin
                next_byte(sel);
                if (obs(sel)[9]) found = 1'b1;
            end
            check("frame_start", {31'b0, found}, 1);
            if (!found) return;
        end else begin
            next_byte(sel);
        end
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) next_byte(sel);
            if (k == 1) begin
                if (sel) PATTERN_w = 2'($urandom_range(0, 3));
                else     PATTERN   = 2'($urandom_range(0, 3));
            end
            if (k == drop_k) begin
                if (sel) EN_w = 1'b0;
                else     EN   = 1'b0;
            end
            check($sformatf("s%0d_p%0d_f%0d_b%0d", sel, pat, fc, k),
                  {21'b0, obs(sel)}, {21'b0, exp_q[k]});
            if (k == abort_k) return;
        end
    endtask

    task automatic run_seq(input bit sel, input int pat, input int nfr,
                           input int drop_k);
        int d0;
        d0 = sel ? done_cnt_w : done_cnt;
        if (sel) begin
            PATTERN_w = 2'(pat);
            EN_w      = 1'b1;
        end else begin
            PATTERN = 2'(pat);
            EN      = 1'b1;
        end
        for (int f = 0; f < nfr; f++) begin
            run_frame(sel, pat, sel ? fc_w : fc_s, f == 0,
                      (f == nfr - 1) ? drop_k : -1, -1);
            if (sel) fc_w++;
            else     fc_s++;
        end
        next_byte(sel);
        check("done_count", (sel ? done_cnt_w : done_cnt) - d0, nfr);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("idle_%0d", i), {21'b0, obs(sel)}, 0);
            next_byte(sel);
        end
    endtask

    initial begin
        int d0;
        logic p0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_pclk", {31'b0, PCLK}, 0);
        check("rst_outs", {21'b0, obs(0)}, 0);
        check("rst_outs_w", {21'b0, obs(1)}, 0);
        @(posedge CLK);
        #1;
        check("rst_pclk_hold", {31'b0, PCLK}, 0);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("pclk_first", {31'b0, PCLK}, 1);
        for (int i = 0; i < 3; i++) begin
            next_byte(0);
            check($sformatf("idle_en0_%0d", i), {21'b0, obs(0)}, 0);
        end

        run_seq(0, 0, 1, LB + 3);
        p0 = PCLK;
        @(posedge CLK);
        #1;
        check("pclk_toggle", {31'b0, PCLK}, {31'b0, ~p0});

        run_seq(0, 1, 1, 10);
        run_seq(0, 2, 1, 20);
        run_seq(0, 3, 2, LB);

        for (int it = 0; it < 6; it++) begin
            run_seq(0, $urandom_range(0, 3), $urandom_range(1, 3),
                    $urandom_range(1, 5 * LB - 2));
        end

        d0 = done_cnt;
        PATTERN = 2'd2;
        EN = 1'b1;
        run_frame(0, 2, fc_s, 1, -1, (VS + BP) * LB + 5);
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        check("abort_pclk", {31'b0, PCLK}, 0);
        check("abort_outs", {21'b0, obs(0)}, 0);
        @(posedge CLK);
        #1;
        check("abort_no_done", done_cnt - d0, 0);
        fc_s = 0;
        fc_w = 0;
        RST_N = 1'b1;
        run_seq(0, 3, 2, LB + 2);

        run_seq(1, 1, 1, 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
